// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared definitions for the register-file write-back block.
//   NREG           - number of architectural registers (2**4)
//   QDEPTH_DEFAULT - default depth of the outstanding-load tag queue
//   wb_src_t       - select for the write-back data mux
package reg_writeback_pkg;

  localparam int NREG           = 16;
  localparam int QDEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_t;

endpackage : reg_writeback_pkg

// File: rtl/reg_writeback_tag_fifo.sv
// wb_tag_fifo: circular FIFO holding destination tags of in-flight loads.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset (empties the FIFO)
//   push, din      - enqueue din (ignored while full)
//   pop            - dequeue head (ignored while empty)
//   full, empty    - occupancy flags
//   count          - number of valid entries
//   head           - oldest entry
//   entry_valid    - per-slot valid bit (slot lies between head and tail)
//   entry_data     - raw slot contents, qualified by entry_valid
module wb_tag_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [W-1:0]                 head,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][W-1:0]      entry_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    push_ok_s;
  logic                    pop_ok_s;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign head        = mem_q[head_q];
  assign entry_data  = mem_q;
  assign push_ok_s   = push & ~full;
  assign pop_ok_s    = pop & ~empty;

  // Next-state for storage, pointers and count; pointers wrap naturally at PW bits.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok_s) begin
      mem_d[tail_q] = din;
      tail_d        = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_ok_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    logic [PW-1:0] idx_s;
    logic [PW-1:0] off_s;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s          = PW'(i);
      off_s          = idx_s - head_q;
      entry_valid[i] = ({1'b0, off_s} < count_q);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : wb_tag_fifo

// File: rtl/reg_writeback.sv
// reg_writeback: drives the register-file write port, merging ALU results with
// in-order load returns. Load destinations are held in a tag queue so that
// returning data can be steered, and a pending mask is exported for issue stalls.
// Ports:
//   clk, reset_n                       - clock, synchronous active-low reset
//   alu_valid/alu_waddr/alu_data       - ALU result; alu_ready = accepted this cycle
//   ld_issue/ld_waddr, ld_ready        - record a load destination when ready
//   mem_rsp_valid/mem_rsp_data         - load data returning in issue order
//   write_en/waddr/wdata               - registered register-file write port
//   pending                            - per-register outstanding-load mask
//   outstanding                        - number of queued loads
//   rsp_err                            - sticky: response arrived with no queued load
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int W      = 8,
  parameter int D      = 4,
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  input  logic [D-1:0]              alu_waddr,
  input  logic [W-1:0]              alu_data,
  output logic                      alu_ready,
  input  logic                      ld_issue,
  input  logic [D-1:0]              ld_waddr,
  output logic                      ld_ready,
  input  logic                      mem_rsp_valid,
  input  logic [W-1:0]              mem_rsp_data,
  output logic                      write_en,
  output logic [D-1:0]              waddr,
  output logic [W-1:0]              wdata,
  output logic [(2**D)-1:0]         pending,
  output logic [$clog2(QDEPTH):0]   outstanding,
  output logic                      rsp_err
);

  localparam int NR = 2**D;

  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic [D-1:0]                  fifo_head_s;
  logic [QDEPTH-1:0]             entry_valid_s;
  logic [QDEPTH-1:0][D-1:0]      entry_data_s;
  logic                          push_s;
  logic                          pop_s;
  wb_src_t                       src_s;

  logic          write_en_q, write_en_d;
  logic [D-1:0]  waddr_q,    waddr_d;
  logic [W-1:0]  wdata_q,    wdata_d;
  logic          rsp_err_q,  rsp_err_d;

  function automatic logic [NR-1:0] onehot(input logic [D-1:0] a);
    logic [NR-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // A full queue refuses pushes even if a pop happens the same cycle.
  assign ld_ready  = ~fifo_full_s;
  assign push_s    = ld_issue & ~fifo_full_s;
  assign pop_s     = mem_rsp_valid & ~fifo_empty_s;
  assign alu_ready = ~pop_s;

  wb_tag_fifo #(
    .W     (D),
    .DEPTH (QDEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push_s),
    .din         (ld_waddr),
    .pop         (pop_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .count       (outstanding),
    .head        (fifo_head_s),
    .entry_valid (entry_valid_s),
    .entry_data  (entry_data_s)
  );

  // Pending mask: OR of one-hot destinations over live queue slots, so duplicates
  // keep the bit set until the last matching load pops.
  always_comb begin
    pending = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      pending = pending | (entry_valid_s[i] ? onehot(entry_data_s[i]) : '0);
    end
  end

  // Write-source arbitration: a real memory pop beats the ALU.
  always_comb begin
    src_s = WB_NONE;
    if (pop_s) begin
      src_s = WB_MEM;
    end else if (alu_valid) begin
      src_s = WB_ALU;
    end else begin
      src_s = WB_NONE;
    end
  end

  // Write-port next state; address/data hold when idle. Spurious responses set rsp_err.
  always_comb begin
    write_en_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (src_s)
      WB_MEM: begin
        write_en_d = 1'b1;
        waddr_d    = fifo_head_s;
        wdata_d    = mem_rsp_data;
      end
      WB_ALU: begin
        write_en_d = 1'b1;
        waddr_d    = alu_waddr;
        wdata_d    = alu_data;
      end
      default: begin
        write_en_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
      end
    endcase
    rsp_err_d = rsp_err_q | (mem_rsp_valid & fifo_empty_s);
  end

  // Registered write port and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_en_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      write_en_q <= write_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign write_en = write_en_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign rsp_err  = rsp_err_q;

endmodule : reg_writeback

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [3:0]  alu_waddr;
  logic [7:0]  alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [3:0]  ld_waddr;
  logic        ld_ready;
  logic        mem_rsp_valid;
  logic [7:0]  mem_rsp_data;
  logic        write_en;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [15:0] pending;
  logic [2:0]  outstanding;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  // Expected register-file writes, {waddr, wdata}, in order.
  logic [11:0] exp_q[$];

  reg_writeback #(.W(8), .D(4), .QDEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_waddr     (alu_waddr),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .ld_issue      (ld_issue),
    .ld_waddr      (ld_waddr),
    .ld_ready      (ld_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .write_en      (write_en),
    .waddr         (waddr),
    .wdata         (wdata),
    .pending       (pending),
    .outstanding   (outstanding),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    logic [11:0] e;
    if (write_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {20'd0, waddr, wdata}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(waddr), int'(e[11:8]));
        chk("wr_data", int'(wdata), int'(e[7:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dst[4];
    dst[0] = 4'd1; dst[1] = 4'd2; dst[2] = 4'd3; dst[3] = 4'd1;

    reset_n = 1'b0; alu_valid = 1'b0; alu_waddr = 4'd0; alu_data = 8'd0;
    ld_issue = 1'b0; ld_waddr = 4'd0; mem_rsp_valid = 1'b0; mem_rsp_data = 8'd0;
    step(); step();
    reset_n = 1'b1;
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ld_ready", int'(ld_ready), 1);

    // ALU only
    alu_valid = 1'b1; alu_waddr = 4'd5; alu_data = 8'h3C; #1;
    chk("alu_ready_idle", int'(alu_ready), 1);
    expect_wr(4'd5, 8'h3C);
    step();
    alu_valid = 1'b0;
    step();
    chk("alu_we_drop", int'(write_en), 0);
    chk("alu_hold_waddr", int'(waddr), 5);
    chk("alu_hold_wdata", int'(wdata), 8'h3C);

    // Load round trip
    ld_issue = 1'b1; ld_waddr = 4'd2; #1;
    chk("ld_ready_empty", int'(ld_ready), 1);
    step();
    ld_issue = 1'b0;
    chk("rt_pending", int'(pending), 16'h0004);
    chk("rt_outstanding", int'(outstanding), 1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 8'hA5; #1;
    chk("rt_alu_ready", int'(alu_ready), 0);
    expect_wr(4'd2, 8'hA5);
    step();
    mem_rsp_valid = 1'b0;
    chk("rt_pending_clr", int'(pending), 0);
    chk("rt_outstanding_clr", int'(outstanding), 0);
    chk("rt_we", int'(write_en), 1);

    // Collision: memory wins, ALU held and written next cycle
    ld_issue = 1'b1; ld_waddr = 4'd7;
    step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_waddr = 4'd1; alu_data = 8'h11;
    mem_rsp_valid = 1'b1; mem_rsp_data = 8'h77; #1;
    chk("col_alu_ready", int'(alu_ready), 0);
    expect_wr(4'd7, 8'h77);
    step();
    mem_rsp_valid = 1'b0; #1;
    chk("col_alu_ready2", int'(alu_ready), 1);
    expect_wr(4'd1, 8'h11);
    step();
    alu_valid = 1'b0;
    step();

    // Full / wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        ld_issue = 1'b1; ld_waddr = dst[i];
        step();
      end
      chk("full_ld_ready", int'(ld_ready), 0);
      chk("full_outstanding", int'(outstanding), 4);
      chk("full_pending", int'(pending), 16'h000E);
      ld_waddr = 4'd9;
      step();
      ld_issue = 1'b0;
      chk("full_ignored_cnt", int'(outstanding), 4);
      chk("full_ignored_pend", int'(pending), 16'h000E);
      for (int i = 0; i < 4; i++) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = 8'h10 + 8'(i);
        if (i == 0) begin
          ld_issue = 1'b1; ld_waddr = 4'd9; #1;
          chk("full_pop_ld_ready", int'(ld_ready), 0);
        end
        expect_wr(dst[i], 8'h10 + 8'(i));
        step();
        ld_issue = 1'b0;
        chk("wrap_outstanding", int'(outstanding), 3 - i);
        chk("wrap_pending1", int'(pending[1]), (i < 3) ? 1 : 0);
      end
      mem_rsp_valid = 1'b0;
      step();
    end

    // Simultaneous push/pop at outstanding=2
    ld_issue = 1'b1; ld_waddr = 4'd4; step();
    ld_waddr = 4'd5; step();
    ld_waddr = 4'd6; mem_rsp_valid = 1'b1; mem_rsp_data = 8'h40;
    expect_wr(4'd4, 8'h40);
    step();
    ld_issue = 1'b0;
    chk("pp_outstanding", int'(outstanding), 2);
    chk("pp_pending", int'(pending), 16'h0060);
    mem_rsp_data = 8'h50; expect_wr(4'd5, 8'h50); step();
    mem_rsp_data = 8'h60; expect_wr(4'd6, 8'h60); step();
    mem_rsp_valid = 1'b0;
    chk("pp_empty", int'(outstanding), 0);
    step();

    // Spurious response; ALU still accepted
    mem_rsp_valid = 1'b1; mem_rsp_data = 8'hEE;
    alu_valid = 1'b1; alu_waddr = 4'd3; alu_data = 8'h33; #1;
    chk("sp_alu_ready", int'(alu_ready), 1);
    expect_wr(4'd3, 8'h33);
    step();
    mem_rsp_valid = 1'b0; alu_valid = 1'b0;
    chk("sp_rsp_err", int'(rsp_err), 1);
    step();
    chk("sp_no_write", int'(write_en), 0);
    chk("sp_rsp_err_held", int'(rsp_err), 1);

    // Reset with three loads in flight
    ld_issue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_waddr = 4'd8 + 4'(i);
      step();
    end
    ld_issue = 1'b0;
    chk("mid_outstanding", int'(outstanding), 3);
    chk("mid_pending", int'(pending), 16'h0700);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mrst_outstanding", int'(outstanding), 0);
    chk("mrst_pending", int'(pending), 0);
    chk("mrst_rsp_err", int'(rsp_err), 0);
    chk("mrst_waddr", int'(waddr), 0);
    chk("mrst_wdata", int'(wdata), 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 8'h99;
    step();
    mem_rsp_valid = 1'b0;
    chk("stale_rsp_err", int'(rsp_err), 1);
    chk("stale_no_write", int'(write_en), 0);
    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_writeback
